// File: rtl/ct_ifu_sram_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// ct_ifu_sram_pkg - shared sizes and FSM type for the IFU 512x44 SRAM controller
// Revision: 1.0
//------------------------------------------------------------------------------
package ct_ifu_sram_pkg;

  localparam int SRAM_DEPTH = 512;
  localparam int SRAM_AW    = 9;
  localparam int SRAM_DW    = 44;

  typedef enum logic [1:0] {
    RST  = 2'd0,
    INIT = 2'd1,
    IDLE = 2'd2
  } sram_ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/ct_ifu_spsram_ctrl_512x44.sv
`default_nettype none
//------------------------------------------------------------------------------
// ct_ifu_spsram_ctrl_512x44 - clear sequencer, read/write arbiter and read return
// for the IFU 512x44 single-port SRAM macro.          Revision: 1.0
//------------------------------------------------------------------------------
module ct_ifu_spsram_ctrl_512x44
  import ct_ifu_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = SRAM_AW,
  parameter int DATA_WIDTH = SRAM_DW,
  parameter int DEPTH      = SRAM_DEPTH
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  inv_req,
  output logic                  inv_busy,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] wr_mask,
  output logic                  wr_rdy,
  input  logic                  rd_vld,
  input  logic [ADDR_WIDTH-1:0] rd_idx,
  output logic                  rd_rdy,
  output logic                  rd_data_vld,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_d,
  output logic [DATA_WIDTH-1:0] sram_wen,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = ADDR_WIDTH'(DEPTH - 1);

  sram_ctrl_state_t      state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] d_q;
  logic                  rd_data_vld_q;
  logic [DATA_WIDTH-1:0] rd_hold_q;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_q <= RST;
    end else begin
      state_q <= state_d;
    end
  end

  // A clear request always restarts the sweep from index 0, even mid-sweep.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST: begin
        state_d = INIT;
        cnt_d   = '0;
      end
      INIT: begin
        if (inv_req) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        if (inv_req) begin
          state_d = INIT;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Address and data fall back to their last driven values when idle.
  always_comb begin
    wr_rdy    = 1'b0;
    rd_rdy    = 1'b0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = a_q;
    sram_d    = d_q;
    case (state_q)
      INIT: begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = cnt_q;
        sram_d    = '0;
      end
      IDLE: begin
        wr_rdy = wr_vld;
        rd_rdy = rd_vld & ~wr_vld;
        if (wr_vld) begin
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = ~wr_mask;
          sram_a    = wr_idx;
          sram_d    = wr_data;
        end else if (rd_vld) begin
          sram_cen = 1'b0;
          sram_a   = rd_idx;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      cnt_q         <= '0;
      a_q           <= '0;
      d_q           <= '0;
      rd_data_vld_q <= 1'b0;
      rd_hold_q     <= '0;
    end else begin
      cnt_q         <= cnt_d;
      a_q           <= sram_a;
      d_q           <= sram_d;
      rd_data_vld_q <= rd_rdy;
      if (rd_data_vld_q) begin
        rd_hold_q <= sram_q;
      end
    end
  end

  assign inv_busy    = (state_q != IDLE);
  assign rd_data_vld = rd_data_vld_q;
  assign rd_data     = rd_data_vld_q ? sram_q : rd_hold_q;

endmodule
`default_nettype wire

// File: doc/ct_ifu_spsram_ctrl_512x44.md
Name: ct_ifu_spsram_ctrl_512x44

Overview:
- Access controller that sits directly upstream of the IFU 512x44 single-port SRAM macro.
- It drives the macro's address, chip-enable, write-enable, data and bit-mask pins, and consumes its Q output.
- It provides a hardware clear sequence after reset and on request, arbitrates one read or write per cycle, and returns read data with a valid strobe.
- All SRAM-side enables are active-low, matching the macro pins.

Parameters:
ADDR_WIDTH, 9, SRAM index width
DATA_WIDTH, 44, SRAM entry width
DEPTH, 512, number of entries (2**ADDR_WIDTH)

Ports:
forever_cpuclk  in  1  single clock
cpurst_b  in  1  asynchronous active-low reset
inv_req  in  1  pulse: clear all entries to zero
inv_busy  out  1  clear sequence in progress (or post-reset)
wr_vld  in  1  write request
wr_idx  in  ADDR_WIDTH  write index
wr_data  in  DATA_WIDTH  write data
wr_mask  in  DATA_WIDTH  per-bit write enable, 1 = write bit
wr_rdy  out  1  write accepted this cycle
rd_vld  in  1  read request
rd_idx  in  ADDR_WIDTH  read index
rd_rdy  out  1  read accepted this cycle
rd_data_vld  out  1  read data valid (1 cycle after accept)
rd_data  out  DATA_WIDTH  read data
sram_a  out  ADDR_WIDTH  to macro A
sram_cen  out  1  to macro CEN, active-low
sram_gwen  out  1  to macro GWEN, 0 = write
sram_d  out  DATA_WIDTH  to macro D
sram_wen  out  DATA_WIDTH  to macro WEN, per-bit active-low
sram_q  in  DATA_WIDTH  from macro Q

Behaviour:
- Clock and reset: one clock, forever_cpuclk. Reset cpurst_b is asynchronous, active-low. All flops clear on cpurst_b low.
- FSM states: RST, INIT, IDLE.
  - Reset state is RST. RST->INIT unconditionally next cycle.
  - INIT: a 9-bit counter cnt starts at 0. Each cycle the block writes sram_a=cnt, sram_cen=0, sram_gwen=0, sram_wen=all 0, sram_d=0, then cnt++.
  - At cnt==DEPTH-1 the FSM goes to IDLE and cnt wraps to 0.
  - IDLE: inv_req=1 -> INIT next cycle with cnt=0. An access accepted in the same cycle still completes.
  - inv_req during INIT restarts the count at 0. inv_req during RST is ignored.
- inv_busy = (state != IDLE). Reset value 1. Deasserts the cycle after the write to index 511.
- Handshake, IDLE only:
  - wr_rdy = wr_vld.
  - rd_rdy = rd_vld & ~wr_vld; write has priority.
  - In RST and INIT, wr_rdy = rd_rdy = 0. Requesters hold requests until accepted.
- Write cycle: sram_a=wr_idx, sram_cen=0, sram_gwen=0, sram_d=wr_data, sram_wen=~wr_mask.
- Read cycle: sram_a=rd_idx, sram_cen=0, sram_gwen=1, sram_wen=all 1.
- No access: sram_cen=1, sram_gwen=1, sram_wen=all 1. sram_a and sram_d hold their last values (registered hold) to reduce toggling.
- Reset values: sram_cen=1, sram_gwen=1, sram_wen=all 1, sram_a=0, sram_d=0.
- Read return:
  - rd_data_vld is a flop; it is 1 exactly one cycle after rd_rdy=1. Reset value 0.
  - rd_data = sram_q when rd_data_vld=1. Otherwise it holds the last captured value (hold register loaded on rd_data_vld). Reset value 0.
- Back-to-back reads give one result per cycle, in order.
- Read-after-write to the same index in the next cycle returns the newly written data; masked-off bits keep their old value.
- Reset asserted mid-INIT or mid-read: everything clears; any pending rd_data_vld is dropped; the sequence restarts at RST.

Decomposition:
- Package ct_ifu_sram_pkg:
  - typedef enum logic [1:0] {RST, INIT, IDLE} sram_ctrl_state_t
  - localparam SRAM_DEPTH=512, SRAM_AW=9, SRAM_DW=44
- No sub-module. The counter, FSM and output mux stay in one module. The macro is instantiated by the parent alongside this block.

Test Plan:
- Release reset -> RST cycle with sram_cen=1. Then 512 consecutive writes to addresses 0..511 with sram_d=0, sram_wen=0. inv_busy falls exactly 513 cycles after release.
- After init: write idx 5, data 44'h123_4567_89AB, mask all 1. Next cycle read idx 5 -> rd_data_vld=1 one cycle later, rd_data=44'h123_4567_89AB.
- Partial write idx 5, data 0, mask 44'h000_0000_FFFF -> sram_wen=44'hFFF_FFFF_0000. Readback = 44'h123_4567_0000.
- rd_vld and wr_vld in the same cycle -> wr_rdy=1, rd_rdy=0. The read is accepted the next cycle; data arrives two cycles after the original request.
- Read idx 5 accepted together with inv_req -> rd_data_vld next cycle with the old data, INIT starts. A subsequent read of idx 5 after inv_busy falls returns 0.
- Drop cpurst_b at cnt=200 during INIT -> sram_cen=1 immediately. After release, the clear restarts from address 0.
